// File: rtl/serial_adder_if.sv
// Operand/result bus and full_adder cell hookup for serial_adder.
// SERIAL_ADDER_SUB_EN adds the i_sub request bit.
interface serial_adder_if #(
  parameter int WIDTH = 8
);
  logic             i_start;
  logic [WIDTH-1:0] i_a;
  logic [WIDTH-1:0] i_b;
  logic             i_cin;
`ifdef SERIAL_ADDER_SUB_EN
  logic             i_sub;
`endif
  logic             o_fa_x;
  logic             o_fa_y;
  logic             o_fa_carry;
  logic             i_fa_sum;
  logic             i_fa_carry;
  logic             o_busy;
  logic             o_done;
  logic [WIDTH-1:0] o_sum;
  logic             o_cout;

  // The master side also owns the full_adder cell outputs it feeds back.
  modport master (
`ifdef SERIAL_ADDER_SUB_EN
    output i_sub,
`endif
    output i_start, i_a, i_b, i_cin, i_fa_sum, i_fa_carry,
    input  o_fa_x, o_fa_y, o_fa_carry, o_busy, o_done, o_sum, o_cout
  );

  modport slave (
`ifdef SERIAL_ADDER_SUB_EN
    input  i_sub,
`endif
    input  i_start, i_a, i_b, i_cin, i_fa_sum, i_fa_carry,
    output o_fa_x, o_fa_y, o_fa_carry, o_busy, o_done, o_sum, o_cout
  );
endinterface

// File: rtl/serial_adder.sv
// Bit-serial WIDTH-bit adder controller driving an external full_adder cell, LSB first.
// Define SERIAL_ADDER_SUB_EN to add the i_sub port (A-B via inverted B and carry-in 1).
module serial_adder #(
  parameter int WIDTH = 8
) (
  input logic           i_clk,
  input logic           i_rst,
  serial_adder_if.slave bus
);

  localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_t;

  state_t           state;
  logic [WIDTH-1:0] a_sr;
  logic [WIDTH-1:0] b_sr;
  logic [WIDTH-1:0] sum_sr;
  logic             carry_reg;
  logic             cout_reg;
  logic [CNT_W-1:0] bit_cnt;
  logic             busy;
  logic             done;

  logic [WIDTH-1:0] b_load;
  logic             carry_load;

`ifdef SERIAL_ADDER_SUB_EN
  always_comb begin
    b_load     = bus.i_b;
    carry_load = bus.i_cin;
    if (bus.i_sub) begin
      b_load     = ~bus.i_b;
      carry_load = 1'b1;
    end
  end
`else
  always_comb begin
    b_load     = bus.i_b;
    carry_load = bus.i_cin;
  end
`endif

  // cout_reg is separate from carry_reg so the visible carry-out only moves on RUN edges.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state     <= IDLE;
      a_sr      <= '0;
      b_sr      <= '0;
      sum_sr    <= '0;
      carry_reg <= 1'b0;
      cout_reg  <= 1'b0;
      bit_cnt   <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          done <= 1'b0;
          if (bus.i_start) begin
            a_sr      <= bus.i_a;
            b_sr      <= b_load;
            carry_reg <= carry_load;
            bit_cnt   <= '0;
            busy      <= 1'b1;
            state     <= RUN;
          end
        end
        RUN: begin
          a_sr      <= a_sr >> 1;
          b_sr      <= b_sr >> 1;
          sum_sr    <= {bus.i_fa_sum, sum_sr[WIDTH-1:1]};
          carry_reg <= bus.i_fa_carry;
          cout_reg  <= bus.i_fa_carry;
          if (bit_cnt == LAST_BIT) begin
            busy  <= 1'b0;
            done  <= 1'b1;
            state <= DONE;
          end else begin
            bit_cnt <= bit_cnt + 1'b1;
          end
        end
        DONE: begin
          done  <= 1'b0;
          state <= IDLE;
        end
        default: begin
          busy  <= 1'b0;
          done  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

  assign bus.o_fa_x     = (state == RUN) & a_sr[0];
  assign bus.o_fa_y     = (state == RUN) & b_sr[0];
  assign bus.o_fa_carry = (state == RUN) & carry_reg;
  assign bus.o_busy     = busy;
  assign bus.o_done     = done;
  assign bus.o_sum      = sum_sr;
  assign bus.o_cout     = cout_reg;

endmodule
